// File: rtl/r_sequencer.sv
// Control FSM for the R (hand) register: sequences the R input mux, write enable,
// memory read strobe, ALU op and inbox/outbox handshakes for one opcode per start.
module r_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       inbox_valid,
  input  logic       outbox_ready,
  output logic       inbox_pop,
  output logic       outbox_push,
  output logic       mem_rd,
  output logic [1:0] muxR,
  output logic       wR,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       done,
  output logic       hand_full,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE, WAIT_IN, MEM_RD, MEM_WAIT, LOAD, WAIT_OUT, DONE, ERR
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_INBOX  = 3'b001;
  localparam logic [2:0] OP_OUTBOX = 3'b010;
  localparam logic [2:0] OP_COPY   = 3'b011;
  localparam logic [2:0] OP_ADD    = 3'b100;
  localparam logic [2:0] OP_SUB    = 3'b101;
  localparam logic [2:0] OP_BUMP   = 3'b110;
  localparam logic [2:0] OP_RSV    = 3'b111;

  // MEM_RD plus (WAIT_INIT+1) MEM_WAIT cycles spans MEM_LAT cycles to LOAD.
  localparam logic [1:0] WAIT_INIT = (MEM_LAT >= 2) ? 2'(MEM_LAT - 2) : 2'd0;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] cnt_q, cnt_d;
  logic       hand_q, hand_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      cnt_q   <= 2'd0;
      hand_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hand_q  <= hand_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    hand_d      = hand_q;
    inbox_pop   = 1'b0;
    outbox_push = 1'b0;
    mem_rd      = 1'b0;
    muxR        = 2'b00;
    wR          = 1'b0;
    alu_op      = 2'b00;
    done        = 1'b0;
    error       = 1'b0;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = opcode;
          if (opcode == OP_RSV) begin
            state_d = ERR;
          end else if ((opcode inside {OP_OUTBOX, OP_ADD, OP_SUB}) && !hand_q) begin
            state_d = ERR;
          end else begin
            case (opcode)
              OP_NOP:    state_d = DONE;
              OP_INBOX:  state_d = WAIT_IN;
              OP_OUTBOX: state_d = WAIT_OUT;
              default:   state_d = MEM_RD;
            endcase
          end
        end
      end
      WAIT_IN: begin
        if (inbox_valid) begin
          inbox_pop = 1'b1;
          wR        = 1'b1;
          muxR      = 2'b00;
          hand_d    = 1'b1;
          state_d   = DONE;
        end
      end
      WAIT_OUT: begin
        if (outbox_ready) begin
          outbox_push = 1'b1;
          hand_d      = 1'b0;
          state_d     = DONE;
        end
      end
      MEM_RD: begin
        mem_rd = 1'b1;
        if (MEM_LAT <= 1) begin
          state_d = LOAD;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (cnt_q == 2'd0) state_d = LOAD;
        else               cnt_d   = cnt_q - 2'd1;
      end
      LOAD: begin
        wR      = 1'b1;
        hand_d  = 1'b1;
        state_d = DONE;
        case (op_q)
          OP_COPY: muxR = 2'b01;
          OP_ADD:  begin muxR = 2'b10; alu_op = 2'b00; end
          OP_SUB:  begin muxR = 2'b10; alu_op = 2'b01; end
          OP_BUMP: begin muxR = 2'b10; alu_op = 2'b10; end
          default: muxR = 2'b01;
        endcase
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        // Terminal until reset: no handshakes, no writes, hand untouched.
        error = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hand_full = hand_q;

endmodule

// File: tb/tb_r_sequencer.sv
// Directed bench for r_sequencer: MEM_LAT=3 main instance plus a MEM_LAT=1 instance
// on shared inputs, with a small R datapath model driven by each instance's controls.
module tb_r_sequencer;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_INBOX  = 3'b001;
  localparam logic [2:0] OP_OUTBOX = 3'b010;
  localparam logic [2:0] OP_COPY   = 3'b011;
  localparam logic [2:0] OP_ADD    = 3'b100;
  localparam logic [2:0] OP_SUB    = 3'b101;
  localparam logic [2:0] OP_BUMP   = 3'b110;

  logic       clk = 1'b0;
  logic       rst, start, inbox_valid, outbox_ready;
  logic [2:0] opcode;
  logic [7:0] inbox_data, mem_data;

  logic       inbox_pop, outbox_push, mem_rd, wR, busy, done, hand_full, error;
  logic [1:0] muxR, alu_op;
  logic       pop1, push1, mrd1, wR1, busy1, done1, hf1, err1;
  logic [1:0] muxR1, alu1;

  logic [7:0] r_q  = 8'h00;
  logic [7:0] r1_q = 8'h00;
  logic [11:0] outs, outs1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  r_sequencer #(.MEM_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .inbox_valid(inbox_valid), .outbox_ready(outbox_ready),
    .inbox_pop(inbox_pop), .outbox_push(outbox_push), .mem_rd(mem_rd),
    .muxR(muxR), .wR(wR), .alu_op(alu_op), .busy(busy), .done(done),
    .hand_full(hand_full), .error(error)
  );

  r_sequencer #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .inbox_valid(inbox_valid), .outbox_ready(outbox_ready),
    .inbox_pop(pop1), .outbox_push(push1), .mem_rd(mrd1),
    .muxR(muxR1), .wR(wR1), .alu_op(alu1), .busy(busy1), .done(done1),
    .hand_full(hf1), .error(err1)
  );

  assign outs  = {inbox_pop, outbox_push, mem_rd, muxR, wR, alu_op, busy, done, hand_full, error};
  assign outs1 = {pop1, push1, mrd1, muxR1, wR1, alu1, busy1, done1, hf1, err1};

  // R datapath model: inbox / memory / ALU sources selected by the sequencer.
  always @(posedge clk) begin
    if (wR) begin
      case (muxR)
        2'b00:   r_q <= inbox_data;
        2'b01:   r_q <= mem_data;
        default: case (alu_op)
                   2'b00:   r_q <= r_q + mem_data;
                   2'b01:   r_q <= r_q - mem_data;
                   default: r_q <= r_q + 8'h01;
                 endcase
      endcase
    end
  end

  always @(posedge clk) begin
    if (wR1) begin
      case (muxR1)
        2'b00:   r1_q <= inbox_data;
        2'b01:   r1_q <= mem_data;
        default: case (alu1)
                   2'b00:   r1_q <= r1_q + mem_data;
                   2'b01:   r1_q <= r1_q - mem_data;
                   default: r1_q <= r1_q + 8'h01;
                 endcase
      endcase
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op);
    start  = 1'b1;
    opcode = op;
    nxt();
    start  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = OP_NOP;
    inbox_valid = 1'b0; outbox_ready = 1'b0;
    inbox_data = 8'h05; mem_data = 8'h00;
    #2;
    chk("reset_outs", 16'(outs), 16'h0);
    chk("reset_outs1", 16'(outs1), 16'h0);
    nxt();
    rst = 1'b0;

    // 1: INBOX with inbox_valid low for three cycles
    run_op(OP_INBOX);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_wait_busy_pop_wr", {busy, inbox_pop, wR}, 3'b100);
      nxt();
    end
    inbox_valid = 1'b1;
    #1;
    chk("t1_pop_wr_mux", {inbox_pop, wR, muxR, done}, 5'b11000);
    nxt();
    inbox_valid = 1'b0;
    #1;
    chk("t1_done_hf_pop_wr", {done, hand_full, inbox_pop, wR}, 4'b1100);
    chk("t1_r_value", r_q, 8'h05);
    nxt(); #1;
    chk("t1_idle", {done, busy}, 2'b00);

    // 2: ADD/SUB with MEM_LAT=3 (dut) and MEM_LAT=1 (dut1)
    inbox_data = 8'h03; inbox_valid = 1'b1;
    run_op(OP_INBOX);
    nxt();
    inbox_valid = 1'b0;
    nxt(); #1;
    chk("t2_r_init", {r_q, r1_q}, 16'h0303);
    mem_data = 8'h07;
    run_op(OP_ADD); #1;
    chk("t2_mem_rd", {mem_rd, mrd1, wR, wR1}, 4'b1100);
    nxt(); #1;
    chk("t2_lat1_load", {wR1, muxR1, alu1}, 5'b1_10_00);
    chk("t2_lat3_wait1", {mem_rd, wR}, 2'b00);
    nxt(); #1;
    chk("t2_lat3_wait2", {mem_rd, wR, done1}, 3'b001);
    nxt(); #1;
    chk("t2_lat3_load", {wR, muxR, alu_op}, 5'b1_10_00);
    nxt(); #1;
    chk("t2_add_done", {done, wR}, 2'b10);
    chk("t2_add_r", {r_q, r1_q}, 16'h0A0A);
    nxt();
    mem_data = 8'h0C;
    run_op(OP_SUB); #1;
    chk("t2_sub_mem_rd", {mem_rd, mrd1}, 2'b11);
    nxt(); #1;
    chk("t2_sub_lat1_load", {wR1, muxR1, alu1}, 5'b1_10_01);
    nxt();
    nxt(); #1;
    chk("t2_sub_lat3_load", {wR, muxR, alu_op}, 5'b1_10_01);
    nxt(); #1;
    chk("t2_sub_r", {r_q, r1_q}, 16'hFEFE);
    nxt();

    // 3: OUTBOX with ready low two cycles, then OUTBOX on empty hand -> ERR
    run_op(OP_OUTBOX); #1;
    chk("t3_wait_out1", {outbox_push, busy}, 2'b01);
    nxt(); #1;
    chk("t3_wait_out2", {outbox_push, busy}, 2'b01);
    nxt();
    outbox_ready = 1'b1;
    #1;
    chk("t3_push", {outbox_push, hand_full}, 2'b11);
    nxt();
    outbox_ready = 1'b0;
    #1;
    chk("t3_done_hf", {done, hand_full, outbox_push}, 3'b100);
    nxt();
    run_op(OP_OUTBOX);
    outbox_ready = 1'b1;
    #1;
    chk("t3_err", {error, busy, done, outbox_push}, 4'b1100);
    nxt(); #1;
    chk("t3_err_hold", {error, busy, done, outbox_push}, 4'b1100);
    inbox_valid = 1'b1;
    run_op(OP_INBOX); #1;
    chk("t3_err_ignore_start", {error, busy, done, inbox_pop, wR}, 5'b11000);
    nxt(); #1;
    chk("t3_err_sticky", {error, busy, done, inbox_pop, wR}, 5'b11000);
    #3 rst = 1'b1;
    #1;
    chk("t3_rst_clear", 16'(outs), 16'h0);
    #2 rst = 1'b0;
    inbox_valid = 1'b0; outbox_ready = 1'b0;
    nxt();

    // 4: start held high through COPYFROM, then launches the next op
    mem_data = 8'h33;
    start = 1'b1; opcode = OP_COPY;
    nxt(); #1;
    chk("t4_mem_rd", {mem_rd, wR}, 2'b10);
    nxt(); #1;
    chk("t4_wait1", {mem_rd, wR, done}, 3'b000);
    nxt(); #1;
    chk("t4_wait2", {mem_rd, wR, done}, 3'b000);
    nxt(); #1;
    chk("t4_load", {wR, muxR, mem_rd}, 4'b1_01_0);
    nxt(); #1;
    chk("t4_done", {done, mem_rd, wR}, 3'b100);
    chk("t4_r_value", r_q, 8'h33);
    nxt();
    opcode = OP_NOP;
    #1;
    chk("t4_idle", {busy, mem_rd, wR, done}, 4'b0000);
    nxt();
    start = 1'b0;
    #1;
    chk("t4_next_op", {done, busy}, 2'b11);
    nxt(); #1;
    chk("t4_back_idle", {done, busy}, 2'b00);

    // 5: async reset in WAIT_OUT and MEM_WAIT, empty-hand ADD, BUMP, reserved
    inbox_data = 8'h40; inbox_valid = 1'b1;
    run_op(OP_INBOX);
    nxt();
    inbox_valid = 1'b0;
    nxt();
    run_op(OP_OUTBOX);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_wait_out", 16'(outs), 16'h0);
    chk("t5_rst_wait_out1", 16'(outs1), 16'h0);
    #2 rst = 1'b0;
    outbox_ready = 1'b1;
    nxt(); #1;
    chk("t5_no_push", {outbox_push, busy, hand_full}, 3'b000);
    nxt();
    outbox_ready = 1'b0;
    run_op(OP_COPY);
    nxt();
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_mem_wait", 16'(outs), 16'h0);
    #2 rst = 1'b0;
    repeat (4) begin
      nxt(); #1;
      chk("t5_no_write", {wR, mem_rd, busy}, 3'b000);
    end
    chk("t5_r_kept", r_q, 8'h40);
    run_op(OP_ADD); #1;
    chk("t5_add_empty_err", {error, busy, mem_rd}, 3'b110);
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    nxt();
    run_op(OP_BUMP);
    repeat (4) nxt();
    #1;
    chk("t5_bump_done", {done, hand_full}, 2'b11);
    chk("t5_bump_r", r_q, 8'h41);
    nxt();
    run_op(3'b111); #1;
    chk("t5_reserved_err", {error, busy, done}, 3'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r_sequencer.md
Name: r_sequencer

Overview:
- Control FSM that sequences the CPU's R (hand) register and its input mux.
- Accepts one decoded opcode per `start` and drives `muxR`/`wR`, the memory read strobe, the ALU op and the inbox/outbox handshakes.
- Tracks whether R holds a value (`hand_full`).
- Sits between the instruction decoder and the R/ALU/memory datapath.

Parameters:
- MEM_LAT, 1: cycles from the `mem_rd` pulse until memory data is valid at R's mem input. Legal range 1..4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to execute `opcode`; sampled only in IDLE.
- opcode  input  3  000 NOP, 001 INBOX, 010 OUTBOX, 011 COPYFROM, 100 ADD, 101 SUB, 110 BUMP, 111 reserved.
- inbox_valid  input  1  inbox has a value on R's inbox input.
- outbox_ready  input  1  outbox can accept R.
- inbox_pop  output  1  inbox consumed this cycle.
- outbox_push  output  1  R written to outbox this cycle.
- mem_rd  output  1  one-cycle memory read strobe.
- muxR  output  2  R source select: 00 inbox, 01 mem, 10 alu.
- wR  output  1  R write enable; R captures at the next rising edge.
- alu_op  output  2  00 add, 01 sub, 10 increment.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- hand_full  output  1  R holds a valid value.
- error  output  1  sticky fault flag.

Behaviour:
- Reset, asynchronous with rst high:
  - State goes to IDLE.
  - All outputs are 0, including `hand_full` and `error`; `muxR` and `alu_op` are 00.
  - Reset mid-operation abandons the operation. No pending pop, push or write survives.
- Outputs are decoded from state plus handshake inputs (Mealy). Outside the states listed below they hold their default value of 0.
- States: IDLE, WAIT_IN, MEM_RD, MEM_WAIT, LOAD, WAIT_OUT, DONE, ERR.
- IDLE, with `start`=1 at edge N: latch `opcode`, then take the first matching rule.
  - Reserved opcode -> ERR.
  - OUTBOX/ADD/SUB with `hand_full`=0 -> ERR.
  - NOP -> DONE.
  - INBOX -> WAIT_IN.
  - OUTBOX -> WAIT_OUT.
  - COPYFROM/ADD/SUB/BUMP -> MEM_RD.
- `start` while busy is ignored; nothing is queued.
- WAIT_IN:
  - Holds while `inbox_valid`=0.
  - When `inbox_valid`=1: `inbox_pop`=1, `wR`=1, `muxR`=00 in the same cycle; R and `hand_full`=1 update at that edge; -> DONE.
- WAIT_OUT:
  - Holds while `outbox_ready`=0.
  - When `outbox_ready`=1: `outbox_push`=1; `hand_full` clears at that edge; -> DONE.
- MEM_RD: `mem_rd`=1 for exactly one cycle.
  - MEM_LAT=1 -> LOAD.
  - Otherwise -> MEM_WAIT with a wait counter loaded with MEM_LAT-2.
- MEM_WAIT: decrement the counter; leave for LOAD when it reaches 0. Total MEM_RD-to-LOAD distance is MEM_LAT cycles.
- LOAD: `wR`=1 for one cycle; `hand_full` sets at the edge; -> DONE.
  - COPYFROM: `muxR`=01.
  - ADD: `muxR`=10, `alu_op`=00.
  - SUB: `muxR`=10, `alu_op`=01.
  - BUMP: `muxR`=10, `alu_op`=10. BUMP is legal with an empty hand.
- DONE: `done`=1 for one cycle, `busy`=1; -> IDLE.
  - A new `start` is accepted from the following cycle (IDLE).
- ERR:
  - `error`=1 and `busy`=1, held until `rst`.
  - No `done` pulse, no `wR`, no handshakes.
  - R and `hand_full` are unchanged.
- `wR`, `inbox_pop`, `outbox_push` and `mem_rd` are never high for more than one cycle per operation, and never outside the states above.
- `inbox_valid`/`outbox_ready` may toggle while waiting. Only the cycle in which the input is sampled high matters.
- Latency from the start edge N, with handshake inputs already high:
  - INBOX: R written at N+1; `done` in cycle N+1..N+2.
  - OUTBOX: push at N+1; `done` in cycle N+1..N+2.
  - COPYFROM/ADD/SUB/BUMP: R written at N+1+MEM_LAT; `done` one cycle later.
  - NOP: `done` in cycle N..N+1 window following N.

Test Plan:
1. Reset, then INBOX with `inbox_valid`=0 for 3 cycles, then 1 -> `inbox_pop`=`wR`=1 together for exactly one cycle with `muxR`=00; R=8'h05 (inbox value); `hand_full`=1; `done` pulses once.
2. MEM_LAT=1 and MEM_LAT=3; memory=8'h07, R=8'h03; ADD -> `mem_rd` one cycle; `wR` exactly MEM_LAT cycles later with `muxR`=10, `alu_op`=00; R=8'h0A. Then SUB with mem=8'h0C -> `alu_op`=01, R=8'hFE (-2).
3. OUTBOX with `outbox_ready` low for 2 cycles, then high -> single `outbox_push`; `hand_full` drops to 0. A following OUTBOX -> ERR: `error`=1 sticky, `done` never pulses, later `start`s ignored until `rst`.
4. `start` held high through an entire COPYFROM -> only one operation executes: one `mem_rd`, one `wR` with `muxR`=01. After `done`, the still-high `start` launches the next op in IDLE.
5. Assert `rst` in WAIT_OUT, and separately in MEM_WAIT -> all outputs 0 immediately (asynchronous), `hand_full`=0, no push or write afterwards. Opcode 111 -> ERR.
